y86_cc_unit: RTL

- Consumer end of the 64-bit execute-stage ALU interface (result, overflow, 2-bit control). Turns ALU output into the Y86-64 condition codes ZF, SF and OF.
- Holds ZF/SF/OF in a register and evaluates the branch/cmov condition for the current ifun.
- Sits in the execute stage between the ALU and the fetch/writeback control.
- Handles pipeline stall and squash, and provides a registered condition output with 1-cycle latency.

---
 rtl/y86_cc_pkg.sv | 24 ++
 rtl/y86_cond_eval.sv | 37 +++
 rtl/y86_cc_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/y86_cc_pkg.sv
// Shared encodings for the Y86-64 condition-code unit: ALU ops, ifun codes,
// CC bit positions and the CC reset value.
package y86_cc_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    localparam logic [3:0] C_ALWAYS = 4'd0;
    localparam logic [3:0] C_LE     = 4'd1;
    localparam logic [3:0] C_L      = 4'd2;
    localparam logic [3:0] C_E      = 4'd3;
    localparam logic [3:0] C_NE     = 4'd4;
    localparam logic [3:0] C_GE     = 4'd5;
    localparam logic [3:0] C_G      = 4'd6;

    localparam int ZF_BIT = 2;
    localparam int SF_BIT = 1;
    localparam int OF_BIT = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/y86_cond_eval.sv
// Combinational Y86-64 condition evaluation from {ZF,SF,OF} and ifun.
// Shared with the fetch-stage branch predictor check.
module y86_cond_eval
    import y86_cc_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cond,
    output logic       ifun_illegal
);

    logic zf;
    logic sf;
    logic of;
    logic lt;

    assign zf = cc[ZF_BIT];
    assign sf = cc[SF_BIT];
    assign of = cc[OF_BIT];
    assign lt = sf ^ of;

    always_comb begin
        cond         = 1'b0;
        ifun_illegal = 1'b0;
        case (ifun)
            C_ALWAYS: cond = 1'b1;
            C_LE:     cond = lt | zf;
            C_L:      cond = lt;
            C_E:      cond = zf;
            C_NE:     cond = ~zf;
            C_GE:     cond = ~lt;
            C_G:      cond = ~lt & ~zf;
            default:  ifun_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/y86_cc_unit.sv
// Execute-stage condition-code register with branch/cmov condition evaluation.
// Optional CC save/restore shadow enabled by defining CC_SNAPSHOT_EN.
module y86_cc_unit
    import y86_cc_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e_valid,
    input  logic             set_cc,
    input  logic             stall,
    input  logic             squash,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic [1:0]       alu_control,
    input  logic [3:0]       ifun,
`ifdef CC_SNAPSHOT_EN
    input  logic             cc_save,
    input  logic             cc_restore,
`endif
    output logic [2:0]       cc_out,
    output logic             cond,
    output logic             cond_q,
    output logic             cond_q_valid,
    output logic             ifun_illegal,
    output logic [CNT_W-1:0] cc_upd_cnt
);

    logic [2:0]       cc_reg;
    logic [2:0]       cc_next;
    logic             cond_q_reg;
    logic             cond_q_valid_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             upd;
    logic [2:0]       alu_flags;

    assign upd = e_valid & set_cc & ~stall & ~squash;

    // Logical ops never overflow, so OF is cleared whatever the ALU reports.
    assign alu_flags[ZF_BIT] = (alu_result == '0);
    assign alu_flags[SF_BIT] = alu_result[WIDTH-1];
    assign alu_flags[OF_BIT] = (alu_control == ALU_ADD || alu_control == ALU_SUB) ? alu_overflow : 1'b0;

    y86_cond_eval u_cond_eval (
        .cc           (cc_reg),
        .ifun         (ifun),
        .cond         (cond),
        .ifun_illegal (ifun_illegal)
    );

`ifdef CC_SNAPSHOT_EN
    logic [2:0] shadow_reg;
    logic       restore;

    assign restore = cc_restore & ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_reg <= CC_RESET;
        end else if (cc_save && !stall) begin
            shadow_reg <= cc_reg;
        end
    end
`endif

    always_comb begin
        cc_next  = cc_reg;
        cnt_next = cnt_reg;
        if (upd) begin
            cc_next = alu_flags;
            if (cnt_reg != '1) begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
`ifdef CC_SNAPSHOT_EN
        // A restore overrides the ALU update and is not counted as one.
        if (restore) begin
            cc_next  = shadow_reg;
            cnt_next = cnt_reg;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_reg           <= CC_RESET;
            cnt_reg          <= '0;
            cond_q_reg       <= 1'b0;
            cond_q_valid_reg <= 1'b0;
        end else begin
            cc_reg  <= cc_next;
            cnt_reg <= cnt_next;
            if (!stall) begin
                cond_q_reg       <= cond;
                cond_q_valid_reg <= e_valid & ~squash;
            end
        end
    end

    assign cc_out       = cc_reg;
    assign cond_q       = cond_q_reg;
    assign cond_q_valid = cond_q_valid_reg;
    assign cc_upd_cnt   = cnt_reg;

endmodule
